// File: rtl/sync_edge_filter_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
//   Shared types and helpers for the sync_edge_filter slice.
//   state_t : qualification FSM states (STABLE, QUAL)
//   qcnt_w  : width of the qualification counter for a given filter length
// ---------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic {
        STABLE,
        QUAL
    } state_t;

    // Counter holds 0..filt-1; sized for filt+1 values so filt==1 still yields width 1.
    function automatic int unsigned qcnt_w(input int unsigned filt);
        return $clog2(filt + 1);
    endfunction

endpackage

// File: rtl/sync_edge_filter_sat_cnt.sv
// ---------------------------------------------------------------------------
// sync_sat_cnt
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   in  1  clock, posedge
//     rst   in  1  synchronous active-high reset (count -> 0)
//     inc   in  1  increment request
//     clr   in  1  clear request; wins over a simultaneous inc
//     count out W  current count, holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sync_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sync_edge_filter.sv
// ---------------------------------------------------------------------------
// sync_edge_filter
//   Glitch filter for an already-synchronized single-bit level. A change on
//   sync_in is accepted only after FILT_CYC consecutive samples that differ
//   from the current filtered level. Produces a registered filtered level,
//   one-cycle rise/fall pulses and a saturating qualified-edge counter.
//
//   Optional feature macro: STICKY_EVENT_EN adds sticky_evt / sticky_clr.
//
//   Ports:
//     clk         in   1      clock, all logic on posedge
//     rst         in   1      synchronous active-high reset
//     sync_in     in   1      synchronized input level
//     cnt_clr     in   1      clear evt_count (wins over increment)
//     sticky_clr  in   1      (STICKY_EVENT_EN) clear sticky_evt
//     sticky_evt  out  1      (STICKY_EVENT_EN) latched "edge accepted"
//     level_out   out  1      filtered level
//     rise_pulse  out  1      one-cycle pulse on accepted 0->1
//     fall_pulse  out  1      one-cycle pulse on accepted 1->0
//     evt_count   out  CNT_W  saturating count of qualified edges
// ---------------------------------------------------------------------------
module sync_edge_filter
    import sync_pkg::*;
#(
    parameter int unsigned FILT_CYC   = 4,
    parameter logic        RST_LVL    = 1'b0,
    parameter int unsigned CNT_W      = 8,
    parameter bit          COUNT_BOTH = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             cnt_clr,
`ifdef STICKY_EVENT_EN
    input  logic             sticky_clr,
    output logic             sticky_evt,
`endif
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_count
);

    localparam int unsigned QW = qcnt_w(FILT_CYC);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [QW-1:0]   r_qcnt;
    logic [QW-1:0]   w_qcnt_nxt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic            w_accept;
    logic            w_differs;
    logic            w_cnt_inc;

    assign w_differs = (sync_in != r_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_accept    = 1'b0;
        unique case (r_state)
            STABLE: begin
                if (w_differs) begin
                    if (FILT_CYC == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = QUAL;
                        w_qcnt_nxt  = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!w_differs) begin
                    // Run broke before qualifying: drop it silently.
                    w_state_nxt = STABLE;
                    w_qcnt_nxt  = '0;
                end else if (r_qcnt == QW'(FILT_CYC - 1)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STABLE;
                    w_qcnt_nxt  = '0;
                end else begin
                    w_qcnt_nxt  = r_qcnt + QW'(1);
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    // Pulse direction comes from the level before the toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= RST_LVL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_accept && !r_level;
            r_fall <= w_accept &&  r_level;
            if (w_accept) begin
                r_level <= ~r_level;
            end
        end
    end

    assign w_cnt_inc = w_accept && (COUNT_BOTH || !r_level);

    sync_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_cnt_inc),
        .clr   (cnt_clr),
        .count (evt_count)
    );

`ifdef STICKY_EVENT_EN
    logic r_sticky;

    // Set has priority so an edge coinciding with a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign sticky_evt = r_sticky;
`endif

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: tb/tb_sync_edge_filter.sv
module tb_sync_edge_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_in = 1'b0;
    logic cnt_clr = 1'b0;
    logic sticky_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance configurations: u0 F=4 W=8 rise-only RST 0; u1 F=1 W=8 both RST 0;
    // u2 F=2 W=2 both RST 1.
    int cf_filt[3] = '{4, 1, 2};
    int cf_w[3]    = '{8, 8, 2};
    int cf_both[3] = '{0, 1, 1};
    int cf_rst[3]  = '{0, 0, 1};

    logic       d_lvl[3];
    logic       d_rise[3];
    logic       d_fall[3];
    logic [7:0] d_cnt[3];
    logic       d_sticky[3];

    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    assign d_cnt[0] = cnt0;
    assign d_cnt[1] = cnt1;
    assign d_cnt[2] = {6'd0, cnt2};

`ifdef STICKY_EVENT_EN
    logic st0, st1, st2;
    assign d_sticky[0] = st0;
    assign d_sticky[1] = st1;
    assign d_sticky[2] = st2;
`else
    assign d_sticky[0] = 1'b0;
    assign d_sticky[1] = 1'b0;
    assign d_sticky[2] = 1'b0;
`endif

    sync_edge_filter #(.FILT_CYC(4), .RST_LVL(1'b0), .CNT_W(8), .COUNT_BOTH(1'b0)) u0 (
        .clk(clk), .rst(rst), .sync_in(sync_in), .cnt_clr(cnt_clr),
`ifdef STICKY_EVENT_EN
        .sticky_clr(sticky_clr), .sticky_evt(st0),
`endif
        .level_out(d_lvl[0]), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]), .evt_count(cnt0)
    );

    sync_edge_filter #(.FILT_CYC(1), .RST_LVL(1'b0), .CNT_W(8), .COUNT_BOTH(1'b1)) u1 (
        .clk(clk), .rst(rst), .sync_in(sync_in), .cnt_clr(cnt_clr),
`ifdef STICKY_EVENT_EN
        .sticky_clr(sticky_clr), .sticky_evt(st1),
`endif
        .level_out(d_lvl[1]), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]), .evt_count(cnt1)
    );

    sync_edge_filter #(.FILT_CYC(2), .RST_LVL(1'b1), .CNT_W(2), .COUNT_BOTH(1'b1)) u2 (
        .clk(clk), .rst(rst), .sync_in(sync_in), .cnt_clr(cnt_clr),
`ifdef STICKY_EVENT_EN
        .sticky_clr(sticky_clr), .sticky_evt(st2),
`endif
        .level_out(d_lvl[2]), .rise_pulse(d_rise[2]), .fall_pulse(d_fall[2]), .evt_count(cnt2)
    );

    // Reference model: level flips once the last F samples (since reset or the
    // previous flip) all disagree with it.
    logic        m_lvl[3];
    logic        m_rise[3];
    logic        m_fall[3];
    int          m_cnt[3];
    logic        m_sticky[3];
    logic [31:0] m_hist[3];
    int          m_nv[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic clr, input logic r, input logic sc);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_lvl[i]    = cf_rst[i][0];
                m_rise[i]   = 1'b0;
                m_fall[i]   = 1'b0;
                m_cnt[i]    = 0;
                m_sticky[i] = 1'b0;
                m_hist[i]   = '0;
                m_nv[i]     = 0;
            end else begin
                logic [31:0] mask;
                logic [31:0] want;
                logic        acc;
                m_hist[i] = {m_hist[i][30:0], s};
                if (m_nv[i] < 32) m_nv[i]++;
                mask = (32'd1 << cf_filt[i]) - 32'd1;
                want = m_lvl[i] ? 32'd0 : mask;
                acc  = (m_nv[i] >= cf_filt[i]) && ((m_hist[i] & mask) == want);
                m_rise[i] = acc && !m_lvl[i];
                m_fall[i] = acc &&  m_lvl[i];
                if (clr)
                    m_cnt[i] = 0;
                else if ((m_rise[i] || (m_fall[i] && cf_both[i] != 0)) &&
                         m_cnt[i] < (1 << cf_w[i]) - 1)
                    m_cnt[i]++;
                if (acc)
                    m_sticky[i] = 1'b1;
                else if (sc)
                    m_sticky[i] = 1'b0;
                if (acc) begin
                    m_lvl[i] = !m_lvl[i];
                    m_nv[i]  = 0;
                end
            end
        end
    endtask

    task automatic step(input logic s, input logic clr, input logic r, input logic sc);
        sync_in    = s;
        cnt_clr    = clr;
        rst        = r;
        sticky_clr = sc;
        @(posedge clk);
        model_edge(s, clr, r, sc);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_level", i), {31'd0, d_lvl[i]},  {31'd0, m_lvl[i]});
            check($sformatf("u%0d_rise", i),  {31'd0, d_rise[i]}, {31'd0, m_rise[i]});
            check($sformatf("u%0d_fall", i),  {31'd0, d_fall[i]}, {31'd0, m_fall[i]});
            check($sformatf("u%0d_count", i), {24'd0, d_cnt[i]},  m_cnt[i]);
`ifdef STICKY_EVENT_EN
            check($sformatf("u%0d_sticky", i), {31'd0, d_sticky[i]}, {31'd0, m_sticky[i]});
`endif
        end
    endtask

    initial begin
        int  hold;
        logic s;

        // Reset two cycles.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_u0_level", {31'd0, d_lvl[0]}, 32'd0);
        check("rst_u0_pulses", {30'd0, d_rise[0], d_fall[0]}, 32'd0);
        check("rst_u0_count", {24'd0, d_cnt[0]}, 32'd0);
        check("rst_u2_level", {31'd0, d_lvl[2]}, 32'd1);

        // Glitch of 3 cycles on the F=4 instance.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("glitch_u0_level", {31'd0, d_lvl[0]}, 32'd0);
        check("glitch_u0_count", {24'd0, d_cnt[0]}, 32'd0);

        // Clean rise held 10 cycles.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 2) check("rise_u0_early", {31'd0, d_lvl[0]}, 32'd0);
            if (k == 3) check("rise_u0_pulse", {31'd0, d_rise[0]}, 32'd1);
            if (k == 4) check("rise_u0_pulse_end", {31'd0, d_rise[0]}, 32'd0);
        end
        check("rise_u0_count", {24'd0, d_cnt[0]}, 32'd1);

        // Fall does not count when only rises are counted.
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("fall_u0_level", {31'd0, d_lvl[0]}, 32'd0);
        check("fall_u0_count", {24'd0, d_cnt[0]}, 32'd1);

        // Reset in the middle of qualification discards progress.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 2) check("rstq_u0_early", {31'd0, d_rise[0]}, 32'd0);
            if (k == 3) check("rstq_u0_pulse", {31'd0, d_rise[0]}, 32'd1);
        end

        // Saturation of the 2-bit counter.
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("sat_u2_count", {24'd0, d_cnt[2]}, 32'd3);

        // Clear coincident with an accepted edge.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_u2_fall", {31'd0, d_fall[2]}, 32'd1);
        check("clr_u2_count", {24'd0, d_cnt[2]}, 32'd0);

        // Randomized runs.
        s = 1'b0;
        for (int n = 0; n < 600; n++) begin
            hold = $urandom_range(1, 6);
            s = ~s;
            for (int h = 0; h < hold; h++) begin
                step(s,
                     ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
